// File: rtl/pi_spi_master.sv
// SPI mode-0 master for the PI memory slave. A request (write or read of
// req_len payload bytes at req_addr) becomes one framed SPI transaction:
// PRE sync pulses, 5-byte header, payload, optional write pad byte, gap.
//
// Handshake: req_start is a one-cycle request strobe that is accepted only
// when busy=0 and done=0; req_wr/req_addr/req_len are captured with it.
// busy stays high until the transaction ends, and done then pulses for
// one cycle. tx_rd is a pop strobe on a first-word-fall-through source:
// tx_data must already be valid in the cycle tx_rd is high. rx_valid is a
// one-cycle strobe qualifying rx_data, with no back-pressure.
module pi_spi_master #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [7:0]  CMD_MEM_WR = 8'hA0,
  parameter logic [7:0]  CMD_MEM_RD = 8'hA1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_start,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_len,
  output logic        busy,
  output logic        done,
  output logic        tx_rd,
  input  logic [7:0]  tx_data,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        spi_clk,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    TAIL = 3'd4,
    GAP  = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  state_t state;
  state_t state_next;

  // captured request
  logic        wr_q;
  logic [31:0] addr_q;
  logic [15:0] len_q;

  // timing and shift datapath
  logic [7:0]  div_cnt;
  logic [8:0]  gap_cnt;
  logic [2:0]  bit_cnt;
  logic [16:0] byte_cnt;
  logic [7:0]  tx_sh;
  logic [6:0]  rx_sh;
  logic [7:0]  tx_hold;

  // decoded conditions
  logic        shifting;
  logic        tick;
  logic        rise_tick;
  logic        fall_tick;
  logic        pre_end;
  logic        byte_end;
  logic        data_last;
  logic        accept;
  logic [16:0] data_bytes;
  logic        next_is_payload;
  logic [7:0]  next_byte;

  // Shared decode: spi_clk edge ticks and byte boundaries.
  always_comb begin
    shifting   = (state == PRE) || (state == HDR) || (state == DATA) || (state == TAIL);
    tick       = shifting && (div_cnt == DIV_LAST);
    rise_tick  = tick && !spi_clk;
    fall_tick  = tick && spi_clk;
    pre_end    = fall_tick && (state == PRE) && (bit_cnt == 3'd1);
    byte_end   = fall_tick && (state != PRE) && (bit_cnt == 3'd7);
    // a read clocks one extra byte for the slave's prefetch
    data_bytes = wr_q ? {1'b0, len_q} : ({1'b0, len_q} + 17'd1);
    data_last  = (byte_cnt == (data_bytes - 17'd1));
    accept     = (state == IDLE) && req_start && !done;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: phase transitions happen on spi_clk falling ticks.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = PRE;
      PRE:  if (pre_end) state_next = HDR;
      HDR:  if (byte_end && (byte_cnt == 17'd4))
              state_next = (wr_q && (len_q == 16'd0)) ? TAIL : DATA;
      DATA: if (byte_end && data_last) state_next = wr_q ? TAIL : GAP;
      TAIL: if (byte_end) state_next = GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy, payload prefetch strobe and the next byte to send.
  always_comb begin
    busy            = (state != IDLE);
    next_is_payload = wr_q && (((state == HDR) && (byte_cnt == 17'd4) && (len_q != 16'd0)) ||
                               ((state == DATA) && !data_last));
    // fetch on the low-phase tick before the last bit of the previous byte
    tx_rd           = rise_tick && (bit_cnt == 3'd7) && next_is_payload;
    next_byte       = 8'hFF;
    if (state == PRE) begin
      next_byte = wr_q ? CMD_MEM_WR : CMD_MEM_RD;
    end else if (state == HDR) begin
      unique case (byte_cnt[2:0])
        3'd0:    next_byte = addr_q[7:0];
        3'd1:    next_byte = addr_q[15:8];
        3'd2:    next_byte = addr_q[23:16];
        3'd3:    next_byte = addr_q[31:24];
        default: next_byte = next_is_payload ? tx_hold : 8'hFF;
      endcase
    end else if (next_is_payload) begin
      next_byte = tx_hold;
    end
  end

  // Datapath: clock divider, serial shifting, receive capture, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      div_cnt  <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx_sh    <= 8'hFF;
      rx_sh    <= '0;
      tx_hold  <= '0;
      spi_clk  <= 1'b0;
      spi_ss   <= 1'b1;
      spi_mosi <= 1'b1;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      done     <= (state == GAP) && (state_next == IDLE);
      rx_valid <= 1'b0;
      spi_ss   <= !((state_next == HDR) || (state_next == DATA) || (state_next == TAIL));
      if (accept) begin
        wr_q   <= req_wr;
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 9'd1;
      else              gap_cnt <= '0;

      if (!shifting) begin
        div_cnt  <= '0;
        spi_clk  <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tx_sh    <= 8'hFF;
        spi_mosi <= 1'b1;
      end else if (!tick) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        spi_clk <= !spi_clk;
        if (!spi_clk) begin
          // rising edge: sample miso
          rx_sh <= {rx_sh[5:0], spi_miso};
          if ((state == DATA) && !wr_q && (bit_cnt == 3'd7) && (byte_cnt != 17'd0)) begin
            rx_valid <= 1'b1;
            rx_data  <= {rx_sh, spi_miso};
          end
          if (tx_rd) tx_hold <= tx_data;
        end else if (pre_end || byte_end) begin
          // falling edge at a byte boundary: present MSB of the next byte
          bit_cnt  <= '0;
          byte_cnt <= (state_next != state) ? 17'd0 : (byte_cnt + 17'd1);
          tx_sh    <= {next_byte[6:0], 1'b1};
          spi_mosi <= next_byte[7];
        end else begin
          bit_cnt  <= bit_cnt + 3'd1;
          tx_sh    <= {tx_sh[6:0], 1'b1};
          spi_mosi <= tx_sh[7];
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_spi_master.sv
// Bench for pi_spi_master: PI slave model on the serial side, scoreboards
// for mosi bytes and received payload, directed transaction sequence.
module tb_pi_spi_master;

  localparam int DIV = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // main DUT signals
  logic        req_start = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        busy, done, tx_rd, rx_valid, spi_clk, spi_ss, spi_mosi;
  logic        spi_miso = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic [7:0]  rx_data;

  // fast (CLK_DIV=1) instance signals
  logic        f_start = 1'b0;
  logic        f_busy, f_done, f_tx_rd, f_rx_valid, f_clk, f_ss, f_mosi;
  logic [7:0]  f_rx_data;

  pi_spi_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .busy(busy), .done(done),
    .tx_rd(tx_rd), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  pi_spi_master #(.CLK_DIV(1)) dut_fast (
    .clk(clk), .rst(rst), .req_start(f_start), .req_wr(1'b1),
    .req_addr(32'h0000_0040), .req_len(16'd0), .busy(f_busy), .done(f_done),
    .tx_rd(f_tx_rd), .tx_data(8'h5A), .rx_data(f_rx_data), .rx_valid(f_rx_valid),
    .spi_clk(f_clk), .spi_ss(f_ss), .spi_mosi(f_mosi), .spi_miso(1'b1)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] mem [0:255];
  bit sb_on = 1'b1;

  // slave / monitor state
  logic clk_q = 1'b0, ss_q = 1'b1, fclk_q = 1'b0;
  int k_in = 0, bit_in = 0, k_out = 0, bit_out = 7;
  logic [7:0] sh_in = '0, ob = 8'hFF, s_cmd = '0, pend_d = '0;
  logic [31:0] s_addr = '0, pend_a = '0;
  bit pend_v = 1'b0, tx_pop = 1'b0;
  int cyc = 0, rise_last = -1, period = 0, pre_rises = 0, pre_last = 0, frame_bytes = 0;
  int tx_rd_cnt = 0, rx_cnt = 0, done_cnt = 0;
  int f_rise_last = -1, f_period = 0, f_pre = 0, f_low = 0, f_done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] slave_byte(input int k);
    logic [7:0] idx;
    if (k <= 5) return 8'hFF;
    idx = s_addr[7:0] + 8'(k - 6);
    return mem[idx];
  endfunction

  // PI slave model and output monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      clk_q = 1'b0; ss_q = 1'b1; fclk_q = 1'b0;
      k_in = 0; bit_in = 0; pend_v = 1'b0; pre_rises = 0;
      spi_miso = 1'b1; tx_pop = 1'b0;
    end else begin
      if (tx_pop) begin
        void'(tx_q.pop_front());
        tx_pop = 1'b0;
      end
      tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      if (tx_rd) begin
        tx_rd_cnt++;
        check("tx_rd_while_clk_low", {31'd0, spi_clk}, 32'd0);
        tx_pop = 1'b1;
      end
      if (rx_valid) begin
        rx_cnt++;
        if (rx_exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
      if (done) done_cnt++;
      // spi_clk rising: slave samples mosi
      if (spi_clk && !clk_q) begin
        if (rise_last >= 0) period = cyc - rise_last;
        rise_last = cyc;
        if (spi_ss) pre_rises++;
        else begin
          sh_in = {sh_in[6:0], spi_mosi};
          bit_in++;
          if (bit_in == 8) begin
            bit_in = 0;
            if (sb_on) begin
              if (exp_q.size() == 0) check("mosi_extra_byte", 32'd1, 32'd0);
              else check("mosi_byte", {24'd0, sh_in}, {24'd0, exp_q.pop_front()});
            end
            if (k_in == 0) s_cmd = sh_in;
            else if (k_in <= 4) s_addr[8*(k_in-1) +: 8] = sh_in;
            else if (s_cmd == 8'hA0) begin
              // slave commits a write byte once the following byte arrives
              if (pend_v) mem[pend_a[7:0]] = pend_d;
              pend_d = sh_in;
              pend_a = s_addr + 32'(k_in - 5);
              pend_v = 1'b1;
            end
            k_in++;
          end
        end
      end
      // slave drives miso: first bit at ss fall, then on each falling edge
      if (!spi_ss && ss_q) begin
        pre_last = pre_rises;
        pre_rises = 0;
        k_out = 0; bit_out = 7;
        ob = slave_byte(0);
        spi_miso = ob[bit_out];
      end else if (!spi_ss && !spi_clk && clk_q) begin
        if (bit_out == 0) begin
          k_out++; bit_out = 7;
          ob = slave_byte(k_out);
        end else bit_out--;
        spi_miso = ob[bit_out];
      end
      if (spi_ss && !ss_q) begin
        frame_bytes = k_in;
        k_in = 0; bit_in = 0; pend_v = 1'b0; spi_miso = 1'b1;
      end
      clk_q = spi_clk; ss_q = spi_ss;
      // fast instance
      if (f_clk && !fclk_q) begin
        if (f_rise_last >= 0) f_period = cyc - f_rise_last;
        f_rise_last = cyc;
        if (f_ss) f_pre++;
        else f_low++;
      end
      if (f_done) f_done_cnt++;
      fclk_q = f_clk;
    end
  end

  // driver tasks
  task automatic push_hdr(input logic wr, input logic [31:0] addr);
    exp_q.push_back(wr ? 8'hA0 : 8'hA1);
    for (int i = 0; i < 4; i++) exp_q.push_back(addr[8*i +: 8]);
  endtask

  task automatic start_txn(input logic wr, input logic [31:0] addr, input logic [15:0] len);
    req_wr = wr; req_addr = addr; req_len = len; req_start = 1'b1;
    @(negedge clk);
    req_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt != d0}, 32'd1);
    repeat (6) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, r0, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB; mem[8'h22] = 8'hCC;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ss", {31'd0, spi_ss}, 32'd1);
    check("rst_clk", {31'd0, spi_clk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx_rd", {31'd0, tx_rd}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // write len=2
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    push_hdr(1'b1, 32'h0180_0010);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'hFF);
    d0 = done_cnt; t0 = tx_rd_cnt;
    start_txn(1'b1, 32'h0180_0010, 16'd2);
    check("wr_busy", {31'd0, busy}, 32'd1);
    wait_done("wr", d0);
    check("wr_tx_rd_count", 32'(tx_rd_cnt - t0), 32'd2);
    check("wr_mem_10", {24'd0, mem[8'h10]}, 32'h11);
    check("wr_mem_11", {24'd0, mem[8'h11]}, 32'h22);
    check("wr_frame_bytes", 32'(frame_bytes), 32'd8);
    check("wr_pre_pulses", 32'(pre_last), 32'd2);
    check("wr_clk_period", 32'(period), 32'(2 * DIV));
    check("wr_exp_empty", 32'(exp_q.size()), 32'd0);

    // read len=3
    push_hdr(1'b0, 32'h0180_0020);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    rx_exp_q.push_back(8'hAA); rx_exp_q.push_back(8'hBB); rx_exp_q.push_back(8'hCC);
    d0 = done_cnt; r0 = rx_cnt;
    start_txn(1'b0, 32'h0180_0020, 16'd3);
    wait_done("rd3", d0);
    check("rd3_rx_count", 32'(rx_cnt - r0), 32'd3);
    check("rd3_frame_bytes", 32'(frame_bytes), 32'd9);
    check("rd3_rx_hold", {24'd0, rx_data}, 32'hCC);
    check("rd3_rx_exp_empty", 32'(rx_exp_q.size()), 32'd0);

    // read len=0, plus a start in the done cycle
    push_hdr(1'b0, 32'h0000_0030);
    exp_q.push_back(8'hFF);
    d0 = done_cnt; r0 = rx_cnt;
    start_txn(1'b0, 32'h0000_0030, 16'd0);
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rd0_done_reached", {31'd0, done}, 32'd1);
    req_wr = 1'b1; req_addr = 32'h0000_0099; req_len = 16'd1; req_start = 1'b1;
    @(negedge clk);
    req_start = 1'b0;
    check("start_on_done_ignored", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("start_on_done_still_idle", {31'd0, busy}, 32'd0);
    check("rd0_done_once", 32'(done_cnt - d0), 32'd1);
    check("rd0_rx_count", 32'(rx_cnt - r0), 32'd0);
    check("rd0_frame_bytes", 32'(frame_bytes), 32'd6);

    // start while busy is ignored
    tx_q.push_back(8'h5C);
    push_hdr(1'b1, 32'h0180_0050);
    exp_q.push_back(8'h5C); exp_q.push_back(8'hFF);
    d0 = done_cnt;
    start_txn(1'b1, 32'h0180_0050, 16'd1);
    repeat (20) @(negedge clk);
    start_txn(1'b0, 32'hDEAD_BEEF, 16'd7);
    wait_done("busy_ign", d0);
    repeat (60) @(negedge clk);
    check("busy_ign_idle", {31'd0, busy}, 32'd0);
    check("busy_ign_single_done", 32'(done_cnt - d0), 32'd1);
    check("busy_ign_frame_bytes", 32'(frame_bytes), 32'd7);
    check("busy_ign_mem_50", {24'd0, mem[8'h50]}, 32'h5C);

    // reset during the 3rd payload byte
    sb_on = 1'b0;
    for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
    start_txn(1'b1, 32'h0180_0060, 16'd4);
    n = 0;
    while (!(k_in == 7 && bit_in == 3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_byte3", 32'(k_in), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("abort_ss", {31'd0, spi_ss}, 32'd1);
    check("abort_clk", {31'd0, spi_clk}, 32'd0);
    check("abort_mosi", {31'd0, spi_mosi}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tx_rd", {31'd0, tx_rd}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_q.delete(); exp_q.delete();
    sb_on = 1'b1;
    @(negedge clk);

    // write after abort
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    push_hdr(1'b1, 32'h0180_0070);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'hFF);
    d0 = done_cnt; t0 = tx_rd_cnt;
    start_txn(1'b1, 32'h0180_0070, 16'd2);
    wait_done("post_abort", d0);
    check("post_abort_mem_70", {24'd0, mem[8'h70]}, 32'h33);
    check("post_abort_mem_71", {24'd0, mem[8'h71]}, 32'h44);
    check("post_abort_tx_rd", 32'(tx_rd_cnt - t0), 32'd2);
    check("post_abort_pre", 32'(pre_last), 32'd2);
    check("post_abort_frame", 32'(frame_bytes), 32'd8);

    // CLK_DIV=1 instance: write len=0
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    n = 0;
    while (f_done_cnt == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("fast_done", 32'(f_done_cnt), 32'd1);
    check("fast_period", 32'(f_period), 32'd2);
    check("fast_pre_pulses", 32'(f_pre), 32'd2);
    check("fast_frame_rises", 32'(f_low), 32'd48);

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_rx_exp_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
